// File: rtl/munoc_apb_slave_decoder.sv
// APB fan-out decoder: one upstream APB bus to NUM_SLAVE fixed-size regions, re-timed SETUP/ACCESS.
// Optional ACCESS-phase timeout abort is built when MUNOC_APB_DECODER_TIMEOUT_EN is defined.
module munoc_apb_slave_decoder #(
    parameter int unsigned BW_PLATFORM_ADDR = 32,
    parameter int unsigned BW_NODE_DATA     = 32,
    parameter int unsigned NUM_SLAVE        = 4,
    parameter logic [BW_PLATFORM_ADDR-1:0] BASE_ADDR = '0,
    parameter int unsigned BW_SLAVE_REGION  = 12,
    parameter int unsigned TIMEOUT_CYCLES   = 256
) (
    input  logic                              clk,
    input  logic                              rstnn,
    input  logic [BW_PLATFORM_ADDR-1:0]       spaddr,
    input  logic                              spwrite,
    input  logic                              spsel,
    input  logic                              spenable,
    input  logic [BW_NODE_DATA-1:0]           spwdata,
    output logic [BW_NODE_DATA-1:0]           sprdata,
    output logic                              spready,
    output logic                              spslverr,
    output logic [BW_PLATFORM_ADDR-1:0]       mpaddr,
    output logic                              mpwrite,
    output logic [NUM_SLAVE-1:0]              mpsel,
    output logic                              mpenable,
    output logic [BW_NODE_DATA-1:0]           mpwdata,
    input  logic [NUM_SLAVE*BW_NODE_DATA-1:0] mprdata,
    input  logic [NUM_SLAVE-1:0]              mpready,
    input  logic [NUM_SLAVE-1:0]              mpslverr,
    output logic                              decode_error,
    output logic                              timeout_error
);

    localparam int unsigned BW_IDX = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;
    localparam logic [BW_PLATFORM_ADDR:0] WINDOW =
        (BW_PLATFORM_ADDR + 1)'(NUM_SLAVE) << BW_SLAVE_REGION;

    if (NUM_SLAVE < 1 || NUM_SLAVE > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("munoc_apb_slave_decoder: NUM_SLAVE or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                      state_q, state_d;
    logic [BW_IDX-1:0]           idx_q, idx_d;
    logic [BW_PLATFORM_ADDR-1:0] mpaddr_q, mpaddr_d;
    logic                        mpwrite_q, mpwrite_d;
    logic [BW_NODE_DATA-1:0]     mpwdata_q, mpwdata_d;
    logic [BW_NODE_DATA-1:0]     rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic                        dec_err_q, dec_err_d;
    logic                        to_err_q, to_err_d;

    // Extra top bit acts as the borrow of spaddr - BASE_ADDR (address below the window).
    logic [BW_PLATFORM_ADDR:0]   diff;
    logic                        mapped;
    logic                        sel_ready;
    logic [BW_NODE_DATA-1:0]     sel_rdata;

    assign diff      = {1'b0, spaddr} - {1'b0, BASE_ADDR};
    assign mapped    = !diff[BW_PLATFORM_ADDR] && ({1'b0, diff[BW_PLATFORM_ADDR-1:0]} < WINDOW);
    assign sel_ready = mpready[idx_q];
    assign sel_rdata = mprdata[int'(idx_q) * BW_NODE_DATA +: BW_NODE_DATA];

`ifdef MUNOC_APB_DECODER_TIMEOUT_EN
    localparam int unsigned BW_CNT = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW_CNT-1:0] CNT_LIMIT = BW_CNT'(TIMEOUT_CYCLES - 1);
    logic [BW_CNT-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            mpaddr_q  <= '0;
            mpwrite_q <= 1'b0;
            mpwdata_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            dec_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mpaddr_q  <= mpaddr_d;
            mpwrite_q <= mpwrite_d;
            mpwdata_q <= mpwdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            dec_err_q <= dec_err_d;
            to_err_q  <= to_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mpaddr_d  = mpaddr_q;
        mpwrite_d = mpwrite_q;
        mpwdata_d = mpwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        dec_err_d = dec_err_q;
        to_err_d  = to_err_q;
`ifdef MUNOC_APB_DECODER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                // spsel with spenable already high in IDLE is a protocol violation: ignore it.
                if (spsel && !spenable) begin
                    mpaddr_d  = spaddr;
                    mpwrite_d = spwrite;
                    mpwdata_d = spwdata;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    dec_err_d = 1'b0;
                    to_err_d  = 1'b0;
                    if (mapped) begin
                        idx_d   = diff[BW_SLAVE_REGION +: BW_IDX];
                        state_d = StSetup;
                    end else begin
                        err_d     = 1'b1;
                        dec_err_d = 1'b1;
                        state_d   = StResp;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
`ifdef MUNOC_APB_DECODER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StAccess: begin
                if (sel_ready) begin
                    rdata_d = mpwrite_q ? '0 : sel_rdata;
                    err_d   = mpslverr[idx_q];
                    state_d = StResp;
                end
`ifdef MUNOC_APB_DECODER_TIMEOUT_EN
                else if (cnt_q == CNT_LIMIT) begin
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    to_err_d = 1'b1;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q + BW_CNT'(1);
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mpsel = '0;
        if (state_q == StSetup || state_q == StAccess) mpsel[idx_q] = 1'b1;
        mpenable      = (state_q == StAccess);
        spready       = (state_q == StResp);
        sprdata       = spready ? rdata_q : '0;
        spslverr      = spready & err_q;
        decode_error  = spready & dec_err_q;
`ifdef MUNOC_APB_DECODER_TIMEOUT_EN
        timeout_error = spready & to_err_q;
`else
        timeout_error = 1'b0 & to_err_q;
`endif
    end

    assign mpaddr  = mpaddr_q;
    assign mpwrite = mpwrite_q;
    assign mpwdata = mpwdata_q;

endmodule

// File: tb/tb_munoc_apb_slave_decoder.sv
// Table-driven bench for munoc_apb_slave_decoder with a simple wait-state peripheral model.
// Timeout expectations follow MUNOC_APB_DECODER_TIMEOUT_EN.
module tb_munoc_apb_slave_decoder;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic           clk = 1'b0;
    logic           rstnn;
    logic [AW-1:0]  spaddr;
    logic           spwrite, spsel, spenable;
    logic [DW-1:0]  spwdata, sprdata;
    logic           spready, spslverr;
    logic [AW-1:0]  mpaddr;
    logic           mpwrite, mpenable;
    logic [NS-1:0]  mpsel;
    logic [DW-1:0]  mpwdata;
    logic [NS*DW-1:0] mprdata;
    logic [NS-1:0]  mpready, mpslverr;
    logic           decode_error, timeout_error;

    munoc_apb_slave_decoder #(
        .BW_PLATFORM_ADDR (AW),
        .BW_NODE_DATA     (DW),
        .NUM_SLAVE        (NS),
        .BASE_ADDR        ('0),
        .BW_SLAVE_REGION  (12),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .clk           (clk),
        .rstnn         (rstnn),
        .spaddr        (spaddr),
        .spwrite       (spwrite),
        .spsel         (spsel),
        .spenable      (spenable),
        .spwdata       (spwdata),
        .sprdata       (sprdata),
        .spready       (spready),
        .spslverr      (spslverr),
        .mpaddr        (mpaddr),
        .mpwrite       (mpwrite),
        .mpsel         (mpsel),
        .mpenable      (mpenable),
        .mpwdata       (mpwdata),
        .mprdata       (mprdata),
        .mpready       (mpready),
        .mpslverr      (mpslverr),
        .decode_error  (decode_error),
        .timeout_error (timeout_error)
    );

    always #5 clk = ~clk;

    // Peripheral model: target slave answers after cfg_wait ACCESS cycles; others return junk.
    int            cfg_slave = 0;
    int            cfg_wait = 0;
    logic [DW-1:0] cfg_rdata = '0;
    logic          cfg_serr = 1'b0;
    int            wait_cnt;

    always_comb begin
        mprdata  = '0;
        mpslverr = '0;
        mpready  = '0;
        for (int i = 0; i < NS; i++) begin
            mprdata[i*DW +: DW] = (i == cfg_slave) ? cfg_rdata : (32'hBAD0_0000 | DW'(i));
        end
        mpslverr[cfg_slave] = cfg_serr;
        if (mpenable && wait_cnt >= cfg_wait) mpready = mpsel;
    end

    always @(posedge clk or negedge rstnn) begin
        if (!rstnn)                         wait_cnt <= 0;
        else if (mpenable && mpready == '0) wait_cnt <= wait_cnt + 1;
        else                                wait_cnt <= 0;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        int            slave;
        int            wait_n;
        logic [DW-1:0] rdata;
        logic          serr;
        logic [NS-1:0] exp_sel;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
        int            exp_dec;
        int            exp_to;
    } vec_t;

    task automatic run_xfer(input vec_t v, input string tag);
        int n = 0;
        bit seen = 0;
        int dec_cnt = 0;
        int to_cnt = 0;
        int multi_hot = 0;
        cfg_slave = v.slave;
        cfg_wait  = v.wait_n;
        cfg_rdata = v.rdata;
        cfg_serr  = v.serr;
        @(negedge clk);
        spaddr = v.addr; spwrite = v.write; spwdata = v.wdata; spsel = 1'b1; spenable = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            spenable = 1'b1;
            if (mpsel != '0 && !$onehot(mpsel)) multi_hot++;
            if (decode_error) dec_cnt++;
            if (timeout_error) to_cnt++;
            if (n == 1 && v.exp_sel != '0) begin
                chk({tag, " setup_sel"}, 64'(mpsel), 64'(v.exp_sel));
                chk({tag, " setup_en"}, 64'(mpenable), 64'(0));
                chk({tag, " mpaddr"}, 64'(mpaddr), 64'(v.addr));
                chk({tag, " mpwrite"}, 64'(mpwrite), 64'(v.write));
                if (v.write) chk({tag, " mpwdata"}, 64'(mpwdata), 64'(v.wdata));
            end
            if (n == 2 && v.exp_sel != '0) begin
                chk({tag, " access_sel"}, 64'(mpsel), 64'(v.exp_sel));
                chk({tag, " access_en"}, 64'(mpenable), 64'(1));
            end
            if (spready) seen = 1;
        end
        chk({tag, " ready_seen"}, 64'(seen), 64'(1));
        chk({tag, " latency"}, 64'(n), 64'(v.exp_lat));
        chk({tag, " sprdata"}, 64'(sprdata), 64'(v.exp_rdata));
        chk({tag, " spslverr"}, 64'(spslverr), 64'(v.exp_err));
        chk({tag, " resp_sel"}, 64'({mpsel, mpenable}), 64'(0));
        spsel = 1'b0; spenable = 1'b0;
        @(negedge clk);
        if (decode_error) dec_cnt++;
        if (timeout_error) to_cnt++;
        chk({tag, " ready_one_cycle"}, 64'(spready), 64'(0));
        chk({tag, " decode_pulses"}, 64'(dec_cnt), 64'(v.exp_dec));
        chk({tag, " timeout_pulses"}, 64'(to_cnt), 64'(v.exp_to));
        chk({tag, " one_hot"}, 64'(multi_hot), 64'(0));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'(mpaddr) | 64'(mpwdata) | 64'(sprdata) |
               64'({mpsel, mpwrite, mpenable, spready, spslverr, decode_error, timeout_error});
    endfunction

    vec_t vecs[10];
    vec_t tv;

    initial begin
        //       addr          wr    wdata         sl wait  rdata         serr sel      exp_rdata     err lat dec to
        vecs[0] = '{32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 1, 0, 32'h1111_1111, 1'b0, 4'b0010, 32'h0,          1'b0, 3, 0, 0};
        vecs[1] = '{32'h0000_3010, 1'b0, 32'h0,         3, 5, 32'h1234_5678, 1'b0, 4'b1000, 32'h1234_5678, 1'b0, 8, 0, 0};
        vecs[2] = '{32'h0000_4000, 1'b0, 32'h0,         0, 0, 32'h7777_7777, 1'b0, 4'b0000, 32'h0,          1'b1, 1, 1, 0};
        vecs[3] = '{32'h0000_0008, 1'b0, 32'h0,         0, 0, 32'hCAFE_F00D, 1'b1, 4'b0001, 32'hCAFE_F00D, 1'b1, 3, 0, 0};
        vecs[4] = '{32'h0000_0FFC, 1'b0, 32'h0,         0, 0, 32'h0BAD_CAFE, 1'b0, 4'b0001, 32'h0BAD_CAFE, 1'b0, 3, 0, 0};
        vecs[5] = '{32'h0000_3000, 1'b0, 32'h0,         3, 0, 32'h3333_0000, 1'b0, 4'b1000, 32'h3333_0000, 1'b0, 3, 0, 0};
        vecs[6] = '{32'h0000_3FFC, 1'b0, 32'h0,         3, 1, 32'hA5A5_5A5A, 1'b0, 4'b1000, 32'hA5A5_5A5A, 1'b0, 4, 0, 0};
        vecs[7] = '{32'h0000_2000, 1'b1, 32'h0102_0304, 2, 2, 32'h9999_9999, 1'b0, 4'b0100, 32'h0,          1'b0, 5, 0, 0};
        vecs[8] = '{32'h0000_1000, 1'b1, 32'h5555_AAAA, 1, 0, 32'h8888_8888, 1'b1, 4'b0010, 32'h0,          1'b1, 3, 0, 0};
        vecs[9] = '{32'hFFFF_FFFC, 1'b1, 32'h0BAD_0BAD, 0, 0, 32'h6666_6666, 1'b0, 4'b0000, 32'h0,          1'b1, 1, 1, 0};

        rstnn = 1'b0; spaddr = '0; spwrite = 1'b0; spsel = 1'b0; spenable = 1'b0; spwdata = '0;
        #1;
        chk("reset_outputs", all_outs(), 64'(0));
        #22;
        @(negedge clk);
        rstnn = 1'b1;

        for (int i = 0; i < 10; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // spsel+spenable together while IDLE must be ignored.
        @(negedge clk);
        spaddr = 32'h0000_1000; spsel = 1'b1; spenable = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_violation", 64'({mpsel, spready}), 64'(0));
        spsel = 1'b0; spenable = 1'b0;

        // spsel dropped right after setup: the transfer still completes at T+3.
        cfg_slave = 2; cfg_wait = 0; cfg_rdata = 32'h2222_2222; cfg_serr = 1'b0;
        @(negedge clk);
        spaddr = 32'h0000_2040; spwrite = 1'b0; spsel = 1'b1; spenable = 1'b0;
        @(negedge clk);
        spsel = 1'b0; spaddr = 32'h0000_0000;
        chk("drop_sel_setup", 64'(mpsel), 64'(4'b0100));
        repeat (2) @(negedge clk);
        chk("drop_sel_ready", 64'(spready), 64'(1));
        chk("drop_sel_rdata", 64'(sprdata), 64'(32'h2222_2222));

`ifdef MUNOC_APB_DECODER_TIMEOUT_EN
        tv = '{32'h0000_2010, 1'b0, 32'h0, 2, 1000000, 32'h4444_4444, 1'b0, 4'b0100,
               32'h0, 1'b1, 18, 0, 1};
        run_xfer(tv, "timeout");
        tv = '{32'h0000_2020, 1'b0, 32'h0, 2, 15, 32'h4545_4545, 1'b0, 4'b0100,
               32'h4545_4545, 1'b0, 18, 0, 0};
        run_xfer(tv, "ready_at_limit");
`else
        cfg_slave = 2; cfg_wait = 1000000; cfg_rdata = 32'h4444_4444;
        @(negedge clk);
        spaddr = 32'h0000_2010; spwrite = 1'b0; spsel = 1'b1; spenable = 1'b0;
        @(negedge clk);
        spenable = 1'b1;
        repeat (1000) @(negedge clk);
        chk("no_timeout_state", 64'({mpsel, mpenable, spready, timeout_error}),
            64'({4'b0100, 1'b1, 1'b0, 1'b0}));
        rstnn = 1'b0;
        spsel = 1'b0; spenable = 1'b0;
        @(negedge clk);
        rstnn = 1'b1;
`endif

        // Reset asserted mid-ACCESS: outputs clear without a clock edge.
        cfg_slave = 1; cfg_wait = 1000000; cfg_rdata = '0;
        @(negedge clk);
        spaddr = 32'h0000_1100; spwrite = 1'b1; spwdata = 32'h1357_9BDF; spsel = 1'b1; spenable = 1'b0;
        repeat (3) @(negedge clk);
        spenable = 1'b1;
        chk("pre_reset_access", 64'({mpsel, mpenable}), 64'({4'b0010, 1'b1}));
        #2 rstnn = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 64'(0));
        spsel = 1'b0; spenable = 1'b0;
        @(negedge clk);
        rstnn = 1'b1;
        tv = '{32'h0000_1200, 1'b1, 32'h2468_ACE0, 1, 0, 32'h0, 1'b0, 4'b0010,
               32'h0, 1'b0, 3, 0, 0};
        run_xfer(tv, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/munoc_apb_slave_decoder.md
Name: munoc_apb_slave_decoder

Overview:
Sits directly downstream of the MUNOC APB slave network interface. It takes the single APB master-side bus the interface drives and fans it out to NUM_SLAVE APB peripherals, each in a fixed-size address region. Every downstream transfer is re-timed through a registered SETUP/ACCESS sequence. Unmapped addresses get an error response locally, and a stalled peripheral is aborted by a timeout (optional feature) so the NoC response path never hangs.

Parameters:
BW_PLATFORM_ADDR, 32, address width.
BW_NODE_DATA, 32, data width.
NUM_SLAVE, 4, number of downstream peripherals; must be 1..16.
BASE_ADDR, 0, base of the decoded window; aligned to (NUM_SLAVE << BW_SLAVE_REGION).
BW_SLAVE_REGION, 12, log2 of region bytes per peripheral.
TIMEOUT_CYCLES, 256, ACCESS cycles before abort; must be >= 2.

Ports:
clk  in  1  clock
rstnn  in  1  reset
spaddr  in  BW_PLATFORM_ADDR  upstream address
spwrite  in  1  upstream write
spsel  in  1  upstream select
spenable  in  1  upstream enable
spwdata  in  BW_NODE_DATA  upstream write data
sprdata  out  BW_NODE_DATA  upstream read data
spready  out  1  upstream ready
spslverr  out  1  upstream error
mpaddr  out  BW_PLATFORM_ADDR  downstream address, registered
mpwrite  out  1  downstream write
mpsel  out  NUM_SLAVE  one-hot downstream select
mpenable  out  1  downstream enable
mpwdata  out  BW_NODE_DATA  downstream write data
mprdata  in  NUM_SLAVE*BW_NODE_DATA  read data; slave i at bits [i*BW_NODE_DATA +: BW_NODE_DATA]
mpready  in  NUM_SLAVE  per-slave ready
mpslverr  in  NUM_SLAVE  per-slave error
decode_error  out  1  one-cycle pulse per unmapped access
timeout_error  out  1  one-cycle pulse per timeout abort

Behaviour:
- Clock and reset: single clock clk. Reset rstnn is asynchronous and active-low.
- Reset values: every output is 0; state is IDLE; the timeout counter is 0.
- Decode:
  - offset = spaddr - BASE_ADDR.
  - The access is mapped when spaddr >= BASE_ADDR and offset < (NUM_SLAVE << BW_SLAVE_REGION).
  - idx = offset >> BW_SLAVE_REGION.
- State IDLE:
  - On spsel=1 and spenable=0, latch spaddr, spwrite and spwdata into mpaddr, mpwrite and mpwdata.
  - If mapped, latch idx and go to SETUP.
  - If unmapped, go to RESP with err=1 and rdata=0, and pulse decode_error in the RESP cycle.
  - spsel=1 together with spenable=1 while IDLE is a protocol violation and is ignored.
- State SETUP: mpsel[idx]=1 and mpenable=0; lasts exactly one cycle, then ACCESS.
- State ACCESS:
  - mpsel[idx]=1 and mpenable=1.
  - When mpready[idx]=1, capture mprdata slice idx and mpslverr[idx], then go to RESP.
  - While waiting, the counter increments on each ACCESS cycle with mpready[idx]=0.
- State RESP:
  - mpsel=0 and mpenable=0.
  - spready=1, with sprdata/spslverr driven from the captured values, for exactly one cycle; then IDLE.
  - sprdata is 0 on writes and on any error generated by this block.
  - spready is 0 in every state other than RESP.
- Latency, zero-wait peripheral: setup seen at cycle T, SETUP at T+1, ACCESS at T+2, spready at T+3. Each peripheral wait cycle adds one.
- Unmapped access: spready at T+1, which is the upstream ACCESS cycle.
- Upstream stability: upstream fields are sampled only in IDLE; changes during a transfer are ignored.
- spsel drop mid-transfer: if spsel falls before RESP, the downstream transfer still completes and RESP still occurs. A new setup is accepted only from IDLE, so a new setup that arrives during RESP is not captured.
- Peripheral error: a slave error (mpslverr=1 with ready) is forwarded on spslverr and raises neither decode_error nor timeout_error.
- Reset mid-operation: all outputs drop to 0 immediately. The aborted transfer produces no response.

Optional Feature:
MUNOC_APB_DECODER_TIMEOUT_EN.
- Defined:
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits and is cleared on entry to ACCESS.
  - If the counter equals TIMEOUT_CYCLES-1 and mpready[idx]=0, the transfer aborts. The next cycle is RESP with err=1 and rdata=0, mpsel/mpenable are deasserted, and timeout_error pulses.
  - If mpready[idx]=1 in the same cycle the limit is reached, ready wins and the transfer completes normally.
- Undefined: the counter and timeout logic are not built, timeout_error is tied to 0, and ACCESS waits indefinitely.

Test Plan:
1. Write 0xDEADBEEF to 0x0000_1004 (BASE_ADDR=0, NUM_SLAVE=4), slave 1 zero-wait -> mpsel=4'b0010 at T+1, mpenable=1 at T+2, mpaddr=0x1004, mpwdata=0xDEADBEEF, spready=1 at T+3 with spslverr=0.
2. Read 0x0000_3010, slave 3 holds mpready low for 5 cycles and returns 0x12345678 -> spready=1 at T+8 with sprdata=0x12345678 for exactly one cycle.
3. Read 0x0000_4000 (unmapped) -> mpsel stays 0, spready=1 at T+1 with spslverr=1 and sprdata=0, decode_error pulses once.
4. With the macro defined and TIMEOUT_CYCLES=16, slave 2 never ready -> mpsel drops after 16 ACCESS cycles, spready=1 with spslverr=1, timeout_error pulses. Without the macro, the block is still in ACCESS after 1000 cycles.
5. Slave 0 returns mpready=1 with mpslverr=1 -> spslverr=1, decode_error=0, timeout_error=0. Back-to-back transfers to slaves 0 then 3 -> mpsel is never multi-hot.
6. rstnn asserted during ACCESS -> all outputs 0 without a clock edge. After release, a write to slave 1 completes at T+3.
